mipi_iodelay_mc: RTL and testbench
==================================

MIPI_IODELAY_MC -- requirements
Module: mipi_iodelay_mc

Interface
REQ-001 SHALL have parameter P_NCH, default 4: number of independent delay channels (1..16).
REQ-002 SHALL have parameter P_DATA_NBIT, default 1: data width per channel.
REQ-003 SHALL have parameter P_DELAY_NBIT, default `MIPI_IODELAY_NBIT: delay-code width; maximum delay is 2**P_DELAY_NBIT-1 cycles.
REQ-004 SHALL have parameter P_CH_NBIT, default 2: channel-select width, with 2**P_CH_NBIT >= P_NCH.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_dio  in  P_NCH*P_DATA_NBIT  channel c occupies bits [c*P_DATA_NBIT +: P_DATA_NBIT].
REQ-008 cfg_req  in  1  configuration request, level, four-phase handshake.
REQ-009 cfg_op  in  2  00 load channel, 01 increment, 10 decrement, 11 load all channels.
REQ-010 cfg_ch  in  P_CH_NBIT  target channel for ops 00/01/10.
REQ-011 cfg_delay  in  P_DELAY_NBIT  delay code for ops 00/11.
REQ-012 cfg_ack  out  1  handshake acknowledge.
REQ-013 cfg_err  out  1  valid while cfg_ack=1: channel out of range or inc/dec saturated.
REQ-014 out_dio  out  P_NCH*P_DATA_NBIT  delayed data, same packing as in_dio.
REQ-015 out_delay  out  P_NCH*P_DELAY_NBIT  current delay code of each channel, same packing.

Function
REQ-016 Each channel SHALL contain a shift chain of 2**P_DELAY_NBIT-1 registers, advancing every clk, stage 1 fed from in_dio.
REQ-017 With delay code d, channel output SHALL equal in_dio of that channel d cycles earlier; d=0 SHALL be a combinational pass-through.
REQ-018 Channel delay codes SHALL be independent registers driven onto out_delay.
REQ-019 Config FSM states: IDLE, APPLY, ACK.
REQ-020 IDLE: on cfg_req=1, capture cfg_op, cfg_ch and cfg_delay, then go to APPLY; cfg_ack=0.
REQ-021 APPLY (exactly 1 cycle): update the delay codes from the captured values, set the error flag, then go to ACK.
REQ-022 ACK: cfg_ack=1 and cfg_err held; on cfg_req=0, go to IDLE with cfg_ack=0 on the next cycle.
REQ-023 Inputs SHALL be sampled only in IDLE; changes while in APPLY or ACK SHALL be ignored.
REQ-024 Op 00: code[cfg_ch] <= cfg_delay.
REQ-025 Op 11: every channel code <= cfg_delay in the same cycle; cfg_ch is ignored; cfg_err=0.
REQ-026 Op 01: if code < 2**P_DELAY_NBIT-1, code+1; otherwise code is unchanged and cfg_err=1 (no wrap).
REQ-027 Op 10: if code > 0, code-1; otherwise code is unchanged and cfg_err=1 (no wrap).
REQ-028 For ops 00/01/10 with cfg_ch >= P_NCH, no code SHALL change and cfg_err SHALL be 1.
REQ-029 A new code SHALL take effect on out_dio the cycle after APPLY; shift chains SHALL NOT be flushed on a code change.
REQ-030 Minimum request-to-ack latency SHALL be 2 cycles: cfg_req seen in IDLE at edge N, cfg_ack=1 after edge N+2.
REQ-031 cfg_req held high continuously SHALL produce exactly one update per handshake; a re-request needs cfg_req=0 first.

Reset
REQ-032 While rst=1: all shift stages 0, all delay codes 0, FSM IDLE, cfg_ack=0, cfg_err=0.
REQ-033 With codes at 0, out_dio SHALL follow in_dio during reset.
REQ-034 Reset asserted mid-handshake SHALL abort the handshake; no partial code update survives.

Verification
REQ-035 Reset, then op 00 ch 1 delay 5; drive a one-cycle 1 on channel 1 -> out_dio channel 1 pulses exactly 5 cycles later, other channels undelayed; out_delay ch1=5.
REQ-036 Op 11 delay 15 -> all out_delay=15, cfg_err=0; an impulse appears 15 cycles later on every channel.
REQ-037 Code 15, op 01 -> code stays 15 and cfg_err=1; code 0, op 10 -> code stays 0 and cfg_err=1.
REQ-038 P_NCH=3, op 00 with cfg_ch=3 -> no code changes and cfg_err=1; handshake completes normally.
REQ-039 Assert cfg_req at edge N -> cfg_ack rises after N+2; hold cfg_req 10 cycles -> single update; drop cfg_req -> cfg_ack low next cycle.
REQ-040 Assert rst during ACK with a pending code of 7 -> cfg_ack=0 immediately, all codes 0, and the FSM accepts a new request after reset release.

Source files
------------

// File: rtl/mipi_iodelay_mc.sv
// Multi-channel programmable data delay line with a four-phase configuration port.
// Each channel taps a fixed-depth shift chain at the stage selected by its delay code.
`ifndef MIPI_IODELAY_NBIT
`define MIPI_IODELAY_NBIT 4
`endif

module mipi_iodelay_mc #(
  parameter int P_NCH        = 4,
  parameter int P_DATA_NBIT  = 1,
  parameter int P_DELAY_NBIT = `MIPI_IODELAY_NBIT,
  parameter int P_CH_NBIT    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_NCH*P_DATA_NBIT-1:0]    in_dio,
  input  logic                            cfg_req,
  input  logic [1:0]                      cfg_op,
  input  logic [P_CH_NBIT-1:0]            cfg_ch,
  input  logic [P_DELAY_NBIT-1:0]         cfg_delay,
  output logic                            cfg_ack,
  output logic                            cfg_err,
  output logic [P_NCH*P_DATA_NBIT-1:0]    out_dio,
  output logic [P_NCH*P_DELAY_NBIT-1:0]   out_delay
);

  localparam int                      L_DEPTH    = (1 << P_DELAY_NBIT) - 1;
  localparam logic [P_DELAY_NBIT-1:0] L_CODE_MAX = {P_DELAY_NBIT{1'b1}};
  localparam logic [P_DELAY_NBIT-1:0] L_CODE_MIN = {P_DELAY_NBIT{1'b0}};
  localparam logic [P_CH_NBIT:0]      L_NCH      = (P_CH_NBIT+1)'(P_NCH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  state_t                    state_r;
  logic [1:0]                cap_op_r;
  logic [P_CH_NBIT-1:0]      cap_ch_r;
  logic [P_DELAY_NBIT-1:0]   cap_delay_r;
  logic                      cfg_ack_r;
  logic                      cfg_err_r;
  logic [P_DELAY_NBIT-1:0]   code_r     [P_NCH];
  logic [P_DELAY_NBIT-1:0]   code_nxt_s [P_NCH];
  logic [P_DATA_NBIT-1:0]    stage_r    [P_NCH][L_DEPTH];
  logic [P_DELAY_NBIT-1:0]   sel_code_s;
  logic                      ch_ok_s;
  logic                      err_nxt_s;
  logic [P_NCH*P_DATA_NBIT-1:0]  out_dio_s;
  logic [P_NCH*P_DELAY_NBIT-1:0] out_delay_s;

  // Free-running shift chains; never flushed by code changes so retuning is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < P_NCH; c++) begin
        for (int s = 0; s < L_DEPTH; s++) begin
          stage_r[c][s] <= {P_DATA_NBIT{1'b0}};
        end
      end
    end else begin
      for (int c = 0; c < P_NCH; c++) begin
        stage_r[c][0] <= in_dio[c*P_DATA_NBIT +: P_DATA_NBIT];
        for (int s = 1; s < L_DEPTH; s++) begin
          stage_r[c][s] <= stage_r[c][s-1];
        end
      end
    end
  end

  // Current code of the captured channel (zero when the channel does not exist)
  always_comb begin
    sel_code_s = {P_DELAY_NBIT{1'b0}};
    for (int c = 0; c < P_NCH; c++) begin
      sel_code_s = sel_code_s |
                   ((cap_ch_r == P_CH_NBIT'(c)) ? code_r[c] : {P_DELAY_NBIT{1'b0}});
    end
    ch_ok_s = ({1'b0, cap_ch_r} < L_NCH);
  end

  // Next delay codes and error flag for the captured request
  always_comb begin
    code_nxt_s = code_r;
    err_nxt_s  = 1'b0;
    case (cap_op_r)
      2'b00: begin
        if (ch_ok_s) begin
          for (int c = 0; c < P_NCH; c++) begin
            if (cap_ch_r == P_CH_NBIT'(c)) code_nxt_s[c] = cap_delay_r;
            else                           code_nxt_s[c] = code_r[c];
          end
        end else begin
          err_nxt_s = 1'b1;
        end
      end
      2'b01: begin
        if (!ch_ok_s || (sel_code_s == L_CODE_MAX)) begin
          err_nxt_s = 1'b1;
        end else begin
          for (int c = 0; c < P_NCH; c++) begin
            if (cap_ch_r == P_CH_NBIT'(c)) code_nxt_s[c] = sel_code_s + P_DELAY_NBIT'(1'b1);
            else                           code_nxt_s[c] = code_r[c];
          end
        end
      end
      2'b10: begin
        if (!ch_ok_s || (sel_code_s == L_CODE_MIN)) begin
          err_nxt_s = 1'b1;
        end else begin
          for (int c = 0; c < P_NCH; c++) begin
            if (cap_ch_r == P_CH_NBIT'(c)) code_nxt_s[c] = sel_code_s - P_DELAY_NBIT'(1'b1);
            else                           code_nxt_s[c] = code_r[c];
          end
        end
      end
      2'b11: begin
        for (int c = 0; c < P_NCH; c++) begin
          code_nxt_s[c] = cap_delay_r;
        end
      end
      default: begin
        code_nxt_s = code_r;
        err_nxt_s  = 1'b0;
      end
    endcase
  end

  // Configuration handshake FSM; owns the delay code registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cap_op_r    <= 2'b00;
      cap_ch_r    <= {P_CH_NBIT{1'b0}};
      cap_delay_r <= {P_DELAY_NBIT{1'b0}};
      cfg_ack_r   <= 1'b0;
      cfg_err_r   <= 1'b0;
      for (int c = 0; c < P_NCH; c++) begin
        code_r[c] <= {P_DELAY_NBIT{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          cfg_ack_r <= 1'b0;
          if (cfg_req) begin
            cap_op_r    <= cfg_op;
            cap_ch_r    <= cfg_ch;
            cap_delay_r <= cfg_delay;
            state_r     <= ST_APPLY;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          code_r    <= code_nxt_s;
          cfg_err_r <= err_nxt_s;
          state_r   <= ST_ACK;
        end
        ST_ACK: begin
          // Release only once the ack has actually been presented
          if (cfg_ack_r && !cfg_req) begin
            cfg_ack_r <= 1'b0;
            cfg_err_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            cfg_ack_r <= 1'b1;
            state_r   <= ST_ACK;
          end
        end
        default: begin
          cfg_ack_r <= 1'b0;
          cfg_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel tap select; code 0 bypasses the chain combinationally
  always_comb begin
    out_dio_s   = in_dio;
    out_delay_s = {(P_NCH*P_DELAY_NBIT){1'b0}};
    for (int c = 0; c < P_NCH; c++) begin
      out_delay_s[c*P_DELAY_NBIT +: P_DELAY_NBIT] = code_r[c];
      if (code_r[c] == L_CODE_MIN) begin
        out_dio_s[c*P_DATA_NBIT +: P_DATA_NBIT] = in_dio[c*P_DATA_NBIT +: P_DATA_NBIT];
      end else begin
        out_dio_s[c*P_DATA_NBIT +: P_DATA_NBIT] = stage_r[c][code_r[c] - P_DELAY_NBIT'(1'b1)];
      end
    end
  end

  assign cfg_ack   = cfg_ack_r;
  assign cfg_err   = cfg_err_r;
  assign out_dio   = out_dio_s;
  assign out_delay = out_delay_s;

endmodule

// File: tb/tb_mipi_iodelay_mc.sv
// Directed bench for mipi_iodelay_mc with three 1-bit channels and 4-bit delay codes.
`timescale 1ns/1ps

module tb_mipi_iodelay_mc;

  localparam int NCH = 3;
  localparam int DW  = 1;
  localparam int CW  = 4;
  localparam int SW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NCH*DW-1:0]    in_dio;
  logic                 cfg_req;
  logic [1:0]           cfg_op;
  logic [SW-1:0]        cfg_ch;
  logic [CW-1:0]        cfg_delay;
  logic                 cfg_ack;
  logic                 cfg_err;
  logic [NCH*DW-1:0]    out_dio;
  logic [NCH*CW-1:0]    out_delay;

  int n_checks = 0;
  int n_errors = 0;
  logic err_s;

  mipi_iodelay_mc #(
    .P_NCH(NCH), .P_DATA_NBIT(DW), .P_DELAY_NBIT(CW), .P_CH_NBIT(SW)
  ) dut (
    .clk(clk), .rst(rst), .in_dio(in_dio),
    .cfg_req(cfg_req), .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .out_dio(out_dio), .out_delay(out_delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake: raise req, wait (bounded) for ack, sample err, drop req, check ack falls
  task automatic do_cfg(input logic [1:0] op, input logic [SW-1:0] ch,
                        input logic [CW-1:0] dly, output logic err);
    int k;
    cfg_op = op; cfg_ch = ch; cfg_delay = dly; cfg_req = 1'b1;
    k = 0;
    while (!cfg_ack && k < 8) begin
      tick();
      k++;
    end
    chk("ack_rise", {31'd0, cfg_ack}, 32'd1);
    err = cfg_err;
    cfg_req = 1'b0;
    tick();
    chk("ack_fall", {31'd0, cfg_ack}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; in_dio = 3'b101; cfg_req = 1'b0;
    cfg_op = 2'b00; cfg_ch = 2'd0; cfg_delay = 4'd0;
    idle(3);
    // Reset state and pass-through during reset
    chk("rst_ack", {31'd0, cfg_ack}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_delay", {20'd0, out_delay}, 32'h000);
    chk("rst_pass_a", {29'd0, out_dio}, 32'h5);
    in_dio = 3'b010;
    #1;
    chk("rst_pass_b", {29'd0, out_dio}, 32'h2);
    tick();
    rst = 1'b0; in_dio = 3'b000;
    idle(2);

    // Load channel 1 with delay 5, then impulse on all channels
    do_cfg(2'b00, 2'd1, 4'd5, err_s);
    chk("ld1_err", {31'd0, err_s}, 32'd0);
    chk("ld1_delay", {20'd0, out_delay}, 32'h050);
    idle(2);
    in_dio = 3'b111;
    #1;
    chk("ld1_t0", {29'd0, out_dio}, 32'h5);
    for (int i = 1; i <= 7; i++) begin
      tick();
      in_dio = 3'b000;
      #1;
      chk("ld1_pulse", {29'd0, out_dio}, (i == 5) ? 32'h2 : 32'h0);
    end

    // Load all channels with 15
    do_cfg(2'b11, 2'd3, 4'd15, err_s);
    chk("all_err", {31'd0, err_s}, 32'd0);
    chk("all_delay", {20'd0, out_delay}, 32'hFFF);
    idle(20);
    in_dio = 3'b111;
    #1;
    chk("all_t0", {29'd0, out_dio}, 32'h0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      in_dio = 3'b000;
      #1;
      chk("all_pulse", {29'd0, out_dio}, (i == 15) ? 32'h7 : 32'h0);
    end

    // Saturation at both ends, plus normal inc/dec
    do_cfg(2'b01, 2'd0, 4'd0, err_s);
    chk("inc_sat_err", {31'd0, err_s}, 32'd1);
    chk("inc_sat_delay", {20'd0, out_delay}, 32'hFFF);
    do_cfg(2'b00, 2'd2, 4'd0, err_s);
    chk("ld2_delay", {20'd0, out_delay}, 32'h0FF);
    do_cfg(2'b10, 2'd2, 4'd9, err_s);
    chk("dec_sat_err", {31'd0, err_s}, 32'd1);
    chk("dec_sat_delay", {20'd0, out_delay}, 32'h0FF);
    do_cfg(2'b01, 2'd2, 4'd0, err_s);
    chk("inc_err", {31'd0, err_s}, 32'd0);
    chk("inc_delay", {20'd0, out_delay}, 32'h1FF);
    do_cfg(2'b10, 2'd0, 4'd0, err_s);
    chk("dec_err", {31'd0, err_s}, 32'd0);
    chk("dec_delay", {20'd0, out_delay}, 32'h1FE);

    // Out-of-range channel
    do_cfg(2'b00, 2'd3, 4'd7, err_s);
    chk("oor_err", {31'd0, err_s}, 32'd1);
    chk("oor_delay", {20'd0, out_delay}, 32'h1FE);
    do_cfg(2'b01, 2'd3, 4'd0, err_s);
    chk("oor_inc_err", {31'd0, err_s}, 32'd1);
    chk("oor_inc_delay", {20'd0, out_delay}, 32'h1FE);

    // Latency and held-request behaviour
    cfg_op = 2'b00; cfg_ch = 2'd0; cfg_delay = 4'd3; cfg_req = 1'b1;
    tick();
    chk("lat_e1", {31'd0, cfg_ack}, 32'd0);
    cfg_delay = 4'd9;
    tick();
    chk("lat_e2", {31'd0, cfg_ack}, 32'd0);
    chk("lat_e2_delay", {20'd0, out_delay}, 32'h1F3);
    tick();
    chk("lat_e3", {31'd0, cfg_ack}, 32'd1);
    chk("lat_err", {31'd0, cfg_err}, 32'd0);
    idle(10);
    chk("hold_ack", {31'd0, cfg_ack}, 32'd1);
    chk("hold_delay", {20'd0, out_delay}, 32'h1F3);
    cfg_req = 1'b0;
    tick();
    chk("hold_drop", {31'd0, cfg_ack}, 32'd0);
    idle(3);
    chk("hold_idle_ack", {31'd0, cfg_ack}, 32'd0);
    chk("hold_idle_delay", {20'd0, out_delay}, 32'h1F3);

    // Reset during ACK with a code of 7 pending on channel 1
    cfg_op = 2'b00; cfg_ch = 2'd1; cfg_delay = 4'd7; cfg_req = 1'b1;
    idle(3);
    chk("mid_ack", {31'd0, cfg_ack}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", {31'd0, cfg_ack}, 32'd0);
    chk("mid_rst_delay", {20'd0, out_delay}, 32'h000);
    cfg_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_delay", {20'd0, out_delay}, 32'h000);
    do_cfg(2'b00, 2'd2, 4'd4, err_s);
    chk("post_rst_err", {31'd0, err_s}, 32'd0);
    chk("post_rst_new", {20'd0, out_delay}, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
